// File: rtl/pwm4096_axil_slave.sv
// AXI4-Lite register slave with a two-channel 2**CNT_WIDTH-step PWM generator.
// Duty values go through shadow registers that reload at the period wrap, so duty changes are glitch-free.
module pwm4096_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned CNT_WIDTH          = 12
) (
    input  logic                              clk,
    input  logic                              reset_p,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [1:0]                        pwm_out,
    output logic                              period_start
);

    localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW      = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned DUTY_W  = CNT_WIDTH + 1;
    localparam int unsigned PRESC_W = 16;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DW-1:0]        ctrl_q, ctrl_d;
    logic [DW-1:0]        duty0_q, duty0_d;
    logic [DW-1:0]        duty1_q, duty1_d;
    logic [DW-1:0]        prescale_q, prescale_d;
    logic                 bvalid_q, bvalid_d;
    logic                 rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0]    shadow0_q, shadow0_d;
    logic [DUTY_W-1:0]    shadow1_q, shadow1_d;
    logic [1:0]           pwm_q, pwm_d;
    logic                 period_start_q, period_start_d;

    logic                 wr_acc_c;
    logic                 rd_acc_c;
    logic                 tick_c;
    logic                 wrap_c;
    logic                 raw0_c;
    logic                 raw1_c;
    logic                 unused_c;

    // Byte-lane merge of a write into a stored register.
    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Handshake accept conditions; readies are a pure function of these.
    always_comb begin
        wr_acc_c = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
        rd_acc_c = s_axi_arvalid & ~rvalid_q;
    end

    // Register file write and write-response channel.
    always_comb begin
        ctrl_d     = ctrl_q;
        duty0_d    = duty0_q;
        duty1_d    = duty1_q;
        prescale_d = prescale_q;
        bvalid_d   = bvalid_q;
        if (wr_acc_c) begin
            bvalid_d = 1'b1;
            case (s_axi_awaddr[3:2])
                2'd0:    ctrl_d     = merge_strb(ctrl_q, s_axi_wdata, s_axi_wstrb);
                2'd1:    duty0_d    = merge_strb(duty0_q, s_axi_wdata, s_axi_wstrb);
                2'd2:    duty1_d    = merge_strb(duty1_q, s_axi_wdata, s_axi_wstrb);
                default: prescale_d = merge_strb(prescale_q, s_axi_wdata, s_axi_wstrb);
            endcase
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read channel samples the registers before any same-edge write lands.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rd_acc_c) begin
            rvalid_d = 1'b1;
            case (s_axi_araddr[3:2])
                2'd0:    rdata_d = ctrl_q;
                2'd1:    rdata_d = duty0_q;
                2'd2:    rdata_d = duty1_q;
                default: rdata_d = prescale_q;
            endcase
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Prescaler and period counter, both held at zero while disabled.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        tick_c  = 1'b0;
        wrap_c  = 1'b0;
        if (!ctrl_q[0]) begin
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            tick_c = (presc_q >= prescale_q[PRESC_W-1:0]);
            if (tick_c) begin
                presc_d = '0;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                wrap_c  = (cnt_q == CNT_MAX);
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Shadow reload and registered output compare, evaluated on next-state values
    // so pwm_out lines up with the counter value it was derived from.
    always_comb begin
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        if (!ctrl_q[0] || wrap_c) begin
            shadow0_d = duty0_q[DUTY_W-1:0];
            shadow1_d = duty1_q[DUTY_W-1:0];
        end
        raw0_c         = ({1'b0, cnt_d} < shadow0_d);
        raw1_c         = ({1'b0, cnt_d} < shadow1_d);
        pwm_d[0]       = ctrl_d[0] & (raw0_c ^ ctrl_d[1]);
        pwm_d[1]       = ctrl_d[0] & (raw1_c ^ ctrl_d[2]);
        period_start_d = wrap_c & ctrl_d[0];
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            ctrl_q         <= '0;
            duty0_q        <= '0;
            duty1_q        <= '0;
            prescale_q     <= '0;
            bvalid_q       <= 1'b0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            presc_q        <= '0;
            cnt_q          <= '0;
            shadow0_q      <= '0;
            shadow1_q      <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            ctrl_q         <= ctrl_d;
            duty0_q        <= duty0_d;
            duty1_q        <= duty1_d;
            prescale_q     <= prescale_d;
            bvalid_q       <= bvalid_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            shadow0_q      <= shadow0_d;
            shadow1_q      <= shadow1_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign s_axi_awready = wr_acc_c;
    assign s_axi_wready  = wr_acc_c;
    assign s_axi_arready = rd_acc_c;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign pwm_out       = pwm_q;
    assign period_start  = period_start_q;

    assign unused_c = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: doc/pwm4096_axil_slave.md
# pwm4096_axil_slave

AXI4-Lite register slave and two-channel 12-bit (4096-step) PWM generator. It is the responder end of the S00_AXI interface driven by the PS or by the master VIP in block-design benches. It decodes four 32-bit registers and produces two PWM outputs whose duty changes are applied glitch-free at period boundaries.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, AXI byte-address width; bits [3:2] select the register.
- CNT_WIDTH, 12, PWM counter width; the period is 2**CNT_WIDTH ticks.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic is on the rising edge.
- reset_p  in  1  synchronous active-high reset.
- s_axi_awaddr  in  4  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  always 2'b00 (OKAY).
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  4  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  always 2'b00.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- pwm_out  out  2  PWM outputs for channel 0 and channel 1.
- period_start  out  1  one-cycle pulse when the counter wraps 4095→0.

## Operation
- Register map. Each register stores all 32 bits and reads back exactly as written.
  - 0x0 CTRL: bit0 enable; bit1 ch0 invert; bit2 ch1 invert.
  - 0x4 DUTY0: bits [12:0].
  - 0x8 DUTY1: bits [12:0].
  - 0xC PRESCALE: bits [15:0].
- Write path.
  - When awvalid, wvalid and !bvalid are all true, awready and wready pulse high together for one cycle.
  - The register selected by awaddr[3:2] is updated on that same edge, honouring wstrb per byte.
  - bvalid rises on the next cycle and holds until bready.
  - No new write is accepted while bvalid=1. If only one of AW/W is valid, nothing is accepted.
- Read path.
  - When arvalid and !rvalid, arready pulses for one cycle.
  - The next cycle, rvalid=1 and rdata returns the register selected by araddr[3:2]. Both hold until rready.
  - If a read and a write are accepted in the same cycle, the read returns the pre-write value.
- Prescaler.
  - A 16-bit counter produces a tick every PRESCALE+1 clocks. PRESCALE=0 gives a tick every clock.
- PWM counter.
  - A 12-bit counter increments on each tick and wraps 4095→0.
  - period_start pulses in the cycle the counter becomes 0 by wrapping.
- Duty shadowing.
  - Shadow duty registers load from DUTY0/DUTY1 on the wrap.
  - While enable=0 they load continuously.
- Output equation.
  - raw = (cnt < shadow). A shadow value ≥ 4096 gives a constant 1; a value of 0 gives a constant 0.
  - pwm_out[n] = enable ? (raw XOR invert[n]) : 0.
- Disable (enable=0): prescaler and counter are held at 0, and period_start stays 0.

## Timing
- Reset values: every register 0, and all handshake outputs 0.
  - bresp=0, rresp=0, rdata=0, pwm_out=0, period_start=0.
  - Counters 0, shadows 0.
- Reset mid-transaction: any pending bvalid/rvalid drops the next cycle with no response. The master must reissue.
- Write latency: write accept to bvalid is 1 cycle; the register changes at the accept edge.
- Read latency: arready to rvalid is 1 cycle.
- Enable 0→1: the counter starts at 0 and pwm_out reflects the shadow on the cycle after the CTRL write.
- A DUTY write mid-period is invisible until the next period_start.
- Changing PRESCALE mid-count: the comparison is cnt ≥ PRESCALE, so shrinking PRESCALE below the current count forces an immediate tick and reset.
- Combinational paths: pwm_out is registered. The ready signals depend only on registered state and the valid inputs.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x0–0xC, then read them back → reads return 0x1,0x2,0x3,0x4 with bresp/rresp=0.
- Write 0xAABBCCDD to 0x8, then 0x11223344 with wstrb=4'b0101 → readback is 0xAA22CC44.
- CTRL=1, PRESCALE=0, DUTY0=2048 → pwm_out[0] is high for 2048 and low for 2048 clocks; period_start every 4096 clocks.
- DUTY0=0 → pwm_out[0] constant 0. DUTY0=4096 → constant 1. CTRL bit1=1 with DUTY0=1024 → low 1024, high 3072.
- DUTY0 changes 100→3000 at counter value 50 → the current period keeps a high time of 100, and the next period has 3000.
- Hold bready=0 after a write, then present a second AW/W → awready/wready stay 0 until the first B handshake. Assert reset_p during a pending rvalid → rvalid=0 and pwm_out=0 next cycle.
